// File: rtl/midi_uart_tx_pkg.sv
// Shared MIDI definitions: status nibbles, serializer/sequencer states and
// the status-byte length decode (also used by the receive framer).
package midi_uart_tx_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYSTEM   = 4'hF;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic {SEQ_IDLE, SEQ_SEND} seq_state_t;

  function automatic logic is_chan_voice(input logic [7:0] status);
    return status[7] && (status[7:4] != SYSTEM);
  endfunction

  // Total bytes on the wire for a status byte; 0 means "not a status byte".
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7]) begin
      case (status[7:4])
        NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: len = 2'd3;
        PROG, CHAN_AT:                          len = 2'd2;
        SYSTEM: begin
          case (status[3:0])
            4'h1, 4'h3: len = 2'd2;
            4'h2:       len = 2'd3;
            default:    len = 2'd1;
          endcase
        end
        default: len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. byte_ready also rises in the last cycle of the stop
// bit so a following byte starts with no idle gap.
module uart_tx_byte
  import midi_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 512
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       bit_idx, bit_idx_next;
  logic [7:0]       shreg, shreg_next;
  logic             tx_q, tx_next;
  logic             wrap, load;

  assign wrap       = (cnt == CNT_MAX);
  assign byte_ready = (state == TX_IDLE) || ((state == TX_STOP) && wrap);
  assign load       = byte_valid && byte_ready;
  assign tx         = tx_q;

  always_comb begin
    state_next   = state;
    cnt_next     = wrap ? '0 : cnt + CNT_W'(1);
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    tx_next      = tx_q;
    case (state)
      TX_IDLE: begin
        cnt_next = '0;
        tx_next  = 1'b1;
      end
      TX_START: begin
        if (wrap) begin
          state_next   = TX_DATA;
          bit_idx_next = 4'd0;
          tx_next      = shreg[0];
        end
      end
      TX_DATA: begin
        if (wrap) begin
          if (bit_idx == 4'd7) begin
            state_next = TX_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 4'd1;
            shreg_next   = {1'b0, shreg[7:1]};
            tx_next      = shreg[1];
          end
        end
      end
      TX_STOP: begin
        if (wrap) begin
          state_next = TX_IDLE;
          tx_next    = 1'b1;
        end
      end
      default: state_next = TX_IDLE;
    endcase
    if (load) begin
      state_next   = TX_START;
      cnt_next     = '0;
      bit_idx_next = 4'd0;
      shreg_next   = byte_data;
      tx_next      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= 4'd0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      tx_q    <= tx_next;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_next;
  end

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI event transmitter: latches one event per handshake, decodes its length,
// applies running status and feeds the bytes to the serializer back to back.
module midi_uart_tx
  import midi_uart_tx_pkg::*;
#(
  parameter int CLK_DIV        = 512,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       midi_event_valid,
  output logic       midi_event_ready,
  input  logic [7:0] midi_command,
  input  logic [6:0] midi_parameter_1,
  input  logic [6:0] midi_parameter_2,
  output logic       serial_tx,
  output logic       busy
);

  seq_state_t seq_state, seq_next;
  logic [1:0] byte_idx, byte_idx_next;
  logic [1:0] msg_len, msg_len_next;
  logic [7:0] last_status, last_status_next;
  logic [7:0] cmd_q;
  logic [6:0] p1_q, p2_q;
  logic       accept, byte_valid, byte_ready;
  logic [7:0] byte_data;
  logic [1:0] len_in, first_idx, next_idx;

  function automatic logic [7:0] pick_byte(input logic [1:0] idx, input logic [7:0] cmd,
                                           input logic [6:0] a, input logic [6:0] b);
    case (idx)
      2'd0:    return cmd;
      2'd1:    return {1'b0, a};
      default: return {1'b0, b};
    endcase
  endfunction

  assign midi_event_ready = (seq_state == SEQ_IDLE);
  assign busy             = (seq_state == SEQ_SEND);
  assign accept           = midi_event_valid && midi_event_ready;
  assign len_in           = midi_msg_len(midi_command);
  assign next_idx         = byte_idx + 2'd1;
  // The first byte is handed over straight from the inputs so the start bit
  // goes out the cycle after acceptance.
  assign first_idx = (RUNNING_STATUS && is_chan_voice(midi_command) &&
                      (midi_command == last_status)) ? 2'd1 : 2'd0;

  always_comb begin
    seq_next         = seq_state;
    byte_idx_next    = byte_idx;
    msg_len_next     = msg_len;
    last_status_next = last_status;
    byte_valid       = 1'b0;
    byte_data        = pick_byte(first_idx, midi_command, midi_parameter_1, midi_parameter_2);
    case (seq_state)
      SEQ_IDLE: begin
        if (accept && (len_in != 2'd0)) begin
          byte_valid    = 1'b1;
          seq_next      = SEQ_SEND;
          byte_idx_next = first_idx;
          msg_len_next  = len_in;
          if (is_chan_voice(midi_command))
            last_status_next = midi_command;
          else if (midi_command[7:3] == 5'b11110)
            last_status_next = 8'h00;
        end
      end
      SEQ_SEND: begin
        byte_data = pick_byte(next_idx, cmd_q, p1_q, p2_q);
        if (byte_ready) begin
          if (next_idx < msg_len) begin
            byte_valid    = 1'b1;
            byte_idx_next = next_idx;
          end else begin
            seq_next = SEQ_IDLE;
          end
        end
      end
      default: seq_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      seq_state   <= SEQ_IDLE;
      byte_idx    <= 2'd0;
      msg_len     <= 2'd0;
      last_status <= 8'h00;
    end else begin
      seq_state   <= seq_next;
      byte_idx    <= byte_idx_next;
      msg_len     <= msg_len_next;
      last_status <= last_status_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q <= midi_command;
      p1_q  <= midi_parameter_1;
      p2_q  <= midi_parameter_2;
    end
  end

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk       (clk),
    .resetn    (resetn),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx        (serial_tx)
  );

endmodule
